// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan controller: FSM states, mode step encoding,
// select wrap point and the default settle length.
package mux_scan_pkg;

  typedef enum logic {
    StSettle = 1'b0,
    StRun    = 1'b1
  } state_e;

  // {mode_fsk, mode_psk}
  typedef enum logic [1:0] {
    ModeF2P2 = 2'b00,
    ModeF2P4 = 2'b01,
    ModeF4P2 = 2'b10,
    ModeF4P4 = 2'b11
  } mode_e;

  localparam logic [2:0]  SEL_LAST       = 3'd7;
  localparam int unsigned SETTLE_CYC_DEF = 3;

  function automatic mode_e mode_step(mode_e m);
    mode_e r;
    unique case (m)
      ModeF2P2: r = ModeF2P4;
      ModeF2P4: r = ModeF4P2;
      ModeF4P2: r = ModeF4P4;
      ModeF4P4: r = ModeF2P2;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] sel_step(logic [2:0] s);
    return (s == SEL_LAST) ? 3'd0 : s + 3'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, optional debounce and registered rising-edge pulse for one raw input.
// Debounce is built only when MUX_SCAN_CTRL_DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic rise
);

  logic [1:0] sync_q;
  logic       level;
  logic       prev_q;
  logic       rise_q;

  if (DEB_CYCLES == 20'd0) begin : g_deb_cycles_zero
    $error("DEB_CYCLES must be nonzero");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

`ifdef MUX_SCAN_CTRL_DEBOUNCE_EN
  logic [19:0] deb_cnt_q;
  logic        level_q;

  // Accept the new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_CYCLES - 20'd1) begin
      deb_cnt_q <= '0;
      level_q   <= sync_q[1];
    end else begin
      deb_cnt_q <= deb_cnt_q + 20'd1;
    end
  end

  assign level = level_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= level;
      rise_q <= level & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/mux_scan_ctrl.sv
// Channel-pair select / modulation-order controller with settle blanking, auto-scan dwell
// and DAC load strobe. Optional button debounce via MUX_SCAN_CTRL_DEBOUNCE_EN.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES = 20'd1_000_000,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_next,
  input  logic        btn_mode,
  input  logic        sw_auto,
  input  logic [31:0] dwell_cycles,
  input  logic        dac_ready,
  output logic [2:0]  sel,
  output logic        mode_fsk,
  output logic        mode_psk,
  output logic        dac_load,
  output logic        busy_settle
);

  localparam int unsigned         SettleW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SettleW-1:0]  SettleLast = SettleW'(SETTLE_CYC - 1);

  state_e             state_q, state_d;
  logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;
  logic [2:0]         sel_q, sel_d;
  mode_e              mode_q, mode_d;
  logic [31:0]        dwell_cnt_q, dwell_cnt_d;
  logic               dac_load_q, dac_load_d;
  logic               busy_q, busy_d;
  logic [1:0]         sw_sync_q;
  logic [1:0]         mode_bits;

  logic next_btn, mode_btn, auto_ev, next_ev, change;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_next_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_next),
    .rise    (next_btn)
  );

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_mode_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_mode),
    .rise    (mode_btn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync_q <= '0;
    end else begin
      sw_sync_q <= {sw_sync_q[0], sw_auto};
    end
  end

  // A simultaneous button and auto event still advance sel only once
  assign auto_ev = (state_q == StRun) & sw_sync_q[1] & (dwell_cycles != 32'd0) &
                   (dwell_cnt_q == dwell_cycles - 32'd1);
  assign next_ev = next_btn | auto_ev;
  assign change  = next_ev | mode_btn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StSettle;
      settle_cnt_q <= '0;
      sel_q        <= 3'd0;
      mode_q       <= ModeF2P2;
      dwell_cnt_q  <= '0;
      dac_load_q   <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      sel_q        <= sel_d;
      mode_q       <= mode_d;
      dwell_cnt_q  <= dwell_cnt_d;
      dac_load_q   <= dac_load_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    if (change) begin
      state_d      = StSettle;
      settle_cnt_d = '0;
    end else if (state_q == StSettle) begin
      if (settle_cnt_q == SettleLast) begin
        state_d      = StRun;
        settle_cnt_d = '0;
      end else begin
        settle_cnt_d = settle_cnt_q + SettleW'(1);
      end
    end
  end

  always_comb begin
    sel_d       = next_ev  ? sel_step(sel_q)   : sel_q;
    mode_d      = mode_btn ? mode_step(mode_q) : mode_q;
    dwell_cnt_d = dwell_cnt_q;
    if (change || !sw_sync_q[1]) begin
      dwell_cnt_d = '0;
    end else if (state_q == StRun) begin
      dwell_cnt_d = dwell_cnt_q + 32'd1;
    end
    dac_load_d  = (state_q == StRun) & dac_ready & ~change;
    busy_d      = (state_d == StSettle);
  end

  assign mode_bits   = mode_q;
  assign sel         = sel_q;
  assign mode_fsk    = mode_bits[1];
  assign mode_psk    = mode_bits[0];
  assign dac_load    = dac_load_q;
  assign busy_settle = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl (default build, no debounce): a timeline reference model
// pushes expected outputs each edge, a monitor pops and compares on the falling edge.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_mode = 1'b0;
  logic        sw_auto = 1'b0;
  logic [31:0] dwell_cycles = 32'd0;
  logic        dac_ready = 1'b0;
  logic [2:0]  sel;
  logic        mode_fsk, mode_psk, dac_load, busy_settle;

  always #5 clk = ~clk;

  mux_scan_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_next     (btn_next),
    .btn_mode     (btn_mode),
    .sw_auto      (sw_auto),
    .dwell_cycles (dwell_cycles),
    .dac_ready    (dac_ready),
    .sel          (sel),
    .mode_fsk     (mode_fsk),
    .mode_psk     (mode_psk),
    .dac_load     (dac_load),
    .busy_settle  (busy_settle)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic [1:0] mode;
    logic       busy;
    logic       load;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: edge-indexed timeline. A change at edge E blanks edges E+1..E+3,
  // a raw rise first sampled at edge k acts at edge k+3, sw_auto acts two edges late.
  int          t;
  int          last_change;
  int          sel_n;
  int          presses;
  logic [31:0] m_dcnt;
  logic [3:0]  n_hist, m_hist;
  logic [1:0]  s_hist;

  always @(posedge clk) begin
    if (!rst_n) begin
      t = 0; last_change = 0; sel_n = 0; presses = 0; m_dcnt = 0;
      n_hist = '0; m_hist = '0; s_hist = '0;
      sb_q.delete();
    end else begin
      bit in_run, nb, mb, ab, chg;
      exp_t e;
      t++;
      in_run = ((t - 1) - last_change) >= 3;
      nb     = n_hist[2] && !n_hist[3];
      mb     = m_hist[2] && !m_hist[3];
      ab     = in_run && s_hist[1] && dwell_cycles != 0 && m_dcnt == dwell_cycles - 32'd1;
      chg    = nb || mb || ab;
      if (nb || ab) sel_n = (sel_n + 1) % 8;
      if (mb) presses++;
      if (chg || !s_hist[1]) m_dcnt = 0;
      else if (in_run) m_dcnt = m_dcnt + 32'd1;
      if (chg) last_change = t;
      e.sel  = 3'(sel_n);
      e.mode = 2'(presses % 4);
      e.busy = !((t - last_change) >= 3);
      e.load = in_run && dac_ready && !chg;
      sb_q.push_back(e);
      n_hist = {n_hist[2:0], btn_next};
      m_hist = {m_hist[2:0], btn_mode};
      s_hist = {s_hist[0], sw_auto};
    end
  end

  exp_t got, want;

  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (sel == 3'd0 && mode_fsk == 1'b0 && mode_psk == 1'b0 && busy_settle && !dac_load)
        passes++;
      else
        $display("FAIL reset_state t=%0t got sel=%0d mode=%b%b busy=%b load=%b want 0/00/1/0",
                 $time, sel, mode_fsk, mode_psk, busy_settle, dac_load);
    end else if (sb_q.size() > 0) begin
      want = sb_q.pop_front();
      got  = '{sel: sel, mode: {mode_fsk, mode_psk}, busy: busy_settle, load: dac_load};
      checks++;
      if (got == want) passes++;
      else
        $display("FAIL outputs t=%0t got sel=%0d mode=%b busy=%b load=%b want sel=%0d mode=%b busy=%b load=%b",
                 $time, got.sel, got.mode, got.busy, got.load,
                 want.sel, want.mode, want.busy, want.load);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_next(input int len);
    btn_next = 1'b1; tick(len); btn_next = 1'b0;
  endtask

  task automatic pulse_mode(input int len);
    btn_mode = 1'b1; tick(len); btn_mode = 1'b0;
  endtask

  task automatic do_reset(input int len);
    rst_n = 1'b0; tick(len); rst_n = 1'b1;
  endtask

  initial begin
    tick(3);
    dac_ready = 1'b1;
    rst_n     = 1'b1;
    tick(12);

    // Auto-scan with dwell 10, long enough to see the 7 -> 0 wrap
    sw_auto = 1'b1; dwell_cycles = 32'd10;
    tick(140);

    // Manual presses, then four mode presses
    sw_auto = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse_next(5); tick($urandom_range(20, 12));
    end
    for (int i = 0; i < 4; i++) begin
      pulse_mode($urandom_range(6, 1)); tick(15);
    end

    // Sweep button phase against auto advance so the two coincide somewhere
    sw_auto = 1'b1; dwell_cycles = 32'd10;
    for (int i = 0; i < 16; i++) begin
      pulse_next(5); tick(14 + i);
    end

    // Back-to-back presses landing inside the settle window
    sw_auto = 1'b0;
    for (int g = 1; g <= 4; g++) begin
      pulse_next(1); tick(g); pulse_next(1); tick(20);
      pulse_next(1); tick(g); pulse_mode(1); tick(20);
    end
    pulse_next(2); pulse_mode(2); tick(20);

    // Dwell 0 disables auto advance
    sw_auto = 1'b1; dwell_cycles = 32'd0;
    for (int i = 0; i < 1000; i++) begin
      dac_ready = 1'($urandom_range(1, 0)); tick(1);
    end
    dac_ready = 1'b1;

    // Lower the dwell below the running count: no advance until the counter wraps
    dwell_cycles = 32'd20; pulse_next(1); tick(18);
    dwell_cycles = 32'd5; tick(60);

    // Reset mid-dwell and mid-settle
    dwell_cycles = 32'd5; tick(7);
    do_reset(2); tick(20);
    pulse_next(2); tick(2);
    do_reset(3); tick(20);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15, 0) == 0) btn_next = ~btn_next;
      if ($urandom_range(23, 0) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(99, 0) == 0) sw_auto = ~sw_auto;
      if ($urandom_range(79, 0) == 0) dwell_cycles = 32'($urandom_range(25, 0));
      dac_ready = 1'($urandom_range(3, 0) != 0);
      tick(1);
    end
    btn_next = 1'b0; btn_mode = 1'b0;
    tick(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
